mc_decoder: RTL and testbench

MC_DECODER -- requirements
Module: mc_decoder

---
 rtl/picomips_pkg.sv | 31 +++
 rtl/mc_decoder_sync_bit.sv | 21 ++
 rtl/mc_decoder.sv | 174 +++++++++++++++++
 tb/tb_mc_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared picoMIPS constants: opcodes, ALU function codes and the
// multi-cycle decoder state type.
package picomips_pkg;

    // Instruction opcodes (low 6 bits of the opcode field)
    localparam logic [5:0] OP_NOP  = 6'b111111;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_MUL  = 6'b000100;
    localparam logic [5:0] OP_MULI = 6'b000101;
    localparam logic [5:0] OP_ADDF = 6'b000110;
    localparam logic [5:0] OP_BAT  = 6'b000111;

    // ALU function select codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_ADDF = 3'b011;
    localparam logic [2:0] ALU_NOP  = 3'b111;

    // RUN: single-cycle decode; MWAIT: multiply in progress;
    // BWAIT: waiting for the switch to leave the branch condition.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_BWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mc_decoder_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the flop chain; clears to 0 on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) chain_q <= '0;
        else       chain_q <= {chain_q[STAGES-2:0], d_i};
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mc_decoder.sv
// Multi-cycle picoMIPS instruction decoder. MUL/MULI stall for a
// configurable number of cycles; BAT stalls until the synchronised
// switch status differs from the branch condition bit.
module mc_decoder
    import picomips_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int MUL_CYCLES  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [3:0]     flags,
    input  logic           Bcond,
    input  logic           Bstus,
    output logic           PCincr,
    output logic           PCabsbranch,
    output logic           PCrelbranch,
    output logic [2:0]     ALUfunc,
    output logic           imm,
    output logic           w,
    output logic           stall,
    output logic           illegal,
    output state_t         dbg_state_o
);

    // First MWAIT cycle counts down from here; the final MWAIT cycle is the write.
    localparam logic [3:0] CNT_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [OPW-1:0] op_q, op_d;
    logic           bcond_q, bcond_d;
    logic           bs_sync;

    logic [OPW-1:0] cur_op;
    logic           cur_bcond;
    logic [5:0]     op_lo;
    logic           upper_nz;
    logic           pcincr_c, stall_c, w_c, imm_c, illegal_c;
    logic [2:0]     alu_c;

    // Flags are reserved for conditional branches in a later revision.
    logic unused_flags;
    assign unused_flags = ^flags;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (Bstus),
        .q_o   (bs_sync)
    );

    // State, wait counter and the instruction latched on entry to a wait state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            op_q    <= '0;
            bcond_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            bcond_q <= bcond_d;
        end
    end

    // Next-state and output decode; wait states decode the latched instruction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        bcond_d   = bcond_q;
        pcincr_c  = 1'b0;
        stall_c   = 1'b0;
        w_c       = 1'b0;
        imm_c     = 1'b0;
        illegal_c = 1'b0;
        alu_c     = ALU_NOP;

        cur_op    = (state_q == ST_RUN) ? opcode : op_q;
        cur_bcond = (state_q == ST_RUN) ? Bcond  : bcond_q;
        op_lo     = cur_op[5:0];
        upper_nz  = (cur_op >> 6) != '0;

        if (!upper_nz) begin
            unique case (op_lo)
                OP_ADD, OP_ADDI: alu_c = ALU_ADD;
                OP_SUB, OP_SUBI: alu_c = ALU_SUB;
                OP_MUL, OP_MULI: alu_c = ALU_MUL;
                OP_ADDF:         alu_c = ALU_ADDF;
                default:         alu_c = ALU_NOP;
            endcase
            imm_c = (op_lo == OP_ADDI) || (op_lo == OP_SUBI) || (op_lo == OP_MULI);
        end

        unique case (state_q)
            ST_RUN: begin
                op_d    = opcode;
                bcond_d = Bcond;
                if (upper_nz) begin
                    pcincr_c  = 1'b1;
                    illegal_c = 1'b1;
                end else begin
                    case (op_lo)
                        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_ADDF: begin
                            pcincr_c = 1'b1;
                            w_c      = 1'b1;
                        end
                        OP_MUL, OP_MULI: begin
                            if (MUL_CYCLES == 1) begin
                                pcincr_c = 1'b1;
                                w_c      = 1'b1;
                            end else begin
                                stall_c = 1'b1;
                                cnt_d   = CNT_LOAD;
                                state_d = ST_MWAIT;
                            end
                        end
                        OP_BAT: begin
                            if (bs_sync != cur_bcond) begin
                                pcincr_c = 1'b1;
                            end else begin
                                stall_c = 1'b1;
                                state_d = ST_BWAIT;
                            end
                        end
                        OP_NOP:  pcincr_c = 1'b1;
                        default: begin
                            pcincr_c  = 1'b1;
                            illegal_c = 1'b1;
                        end
                    endcase
                end
            end
            ST_MWAIT: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    w_c      = 1'b1;
                    pcincr_c = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_BWAIT: begin
                if (bs_sync == cur_bcond) begin
                    stall_c = 1'b1;
                end else begin
                    pcincr_c = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // All outputs are forced low while reset is held.
    always_comb begin
        PCincr      = pcincr_c  & ~reset;
        stall       = stall_c   & ~reset;
        w           = w_c       & ~reset;
        imm         = imm_c     & ~reset;
        illegal     = illegal_c & ~reset;
        ALUfunc     = reset ? 3'b000 : alu_c;
        PCabsbranch = 1'b0;
        PCrelbranch = 1'b0;
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_decoder.sv
// Directed bench for mc_decoder (OPW=8 so upper-bit illegality is reachable).
module tb_mc_decoder;
    import picomips_pkg::*;

    localparam int OPW = 8;
    localparam int MUL_CYCLES = 3;
    localparam int SYNC_STAGES = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [OPW-1:0] opcode;
    logic [3:0]     flags;
    logic           Bcond, Bstus;
    logic           PCincr, PCabsbranch, PCrelbranch, imm, w, stall, illegal;
    logic [2:0]     ALUfunc;
    state_t         dbg_state;

    int errors = 0;
    int checks = 0;

    mc_decoder #(.OPW(OPW), .MUL_CYCLES(MUL_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .flags       (flags),
        .Bcond       (Bcond),
        .Bstus       (Bstus),
        .PCincr      (PCincr),
        .PCabsbranch (PCabsbranch),
        .PCrelbranch (PCrelbranch),
        .ALUfunc     (ALUfunc),
        .imm         (imm),
        .w           (w),
        .stall       (stall),
        .illegal     (illegal),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Expected output word: {PCincr, PCabs, PCrel, stall, w, imm, illegal, ALUfunc}
    function automatic logic [9:0] ev(logic pc, logic st, logic wr, logic im, logic ill, logic [2:0] alu);
        return {pc, 1'b0, 1'b0, st, wr, im, ill, alu};
    endfunction

    function automatic logic [9:0] act();
        return {PCincr, PCabsbranch, PCrelbranch, stall, w, imm, illegal, ALUfunc};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pc,abs,rel,stall,w,imm,ill,alu)", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input state_t exp);
        checks++;
        if (dbg_state !== exp) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string          name;
        logic [OPW-1:0] op;
        logic           bcond;
        logic [9:0]     exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset  = 1'b1;
        opcode = {2'b00, OP_ADD};
        flags  = 4'b1010;
        Bcond  = 1'b0;
        Bstus  = 1'b0;

        // ---- Reset held two cycles with ADD on the bus ----
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", i), act(), 10'b0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        check("reset_release_add", act(), ev(1, 0, 1, 0, 0, ALU_ADD));
        check_state("reset_release_state", ST_RUN);
        next_cycle();

        // ---- Single-cycle instruction table ----
        tbl.push_back('{"nop",     {2'b00, OP_NOP},  1'b0, ev(1, 0, 0, 0, 0, ALU_NOP)});
        tbl.push_back('{"add",     {2'b00, OP_ADD},  1'b0, ev(1, 0, 1, 0, 0, ALU_ADD)});
        tbl.push_back('{"addi",    {2'b00, OP_ADDI}, 1'b0, ev(1, 0, 1, 1, 0, ALU_ADD)});
        tbl.push_back('{"sub",     {2'b00, OP_SUB},  1'b0, ev(1, 0, 1, 0, 0, ALU_SUB)});
        tbl.push_back('{"subi",    {2'b00, OP_SUBI}, 1'b0, ev(1, 0, 1, 1, 0, ALU_SUB)});
        tbl.push_back('{"addf",    {2'b00, OP_ADDF}, 1'b0, ev(1, 0, 1, 0, 0, ALU_ADDF)});
        tbl.push_back('{"undef",   8'b00101010,      1'b0, ev(1, 0, 0, 0, 1, ALU_NOP)});
        tbl.push_back('{"upper",   {2'b01, OP_ADD},  1'b0, ev(1, 0, 0, 0, 1, ALU_NOP)});
        tbl.push_back('{"bat_go",  {2'b00, OP_BAT},  1'b1, ev(1, 0, 0, 0, 0, ALU_NOP)});
        tbl.push_back('{"add_end", {2'b00, OP_ADD},  1'b0, ev(1, 0, 1, 0, 0, ALU_ADD)});
        foreach (tbl[i]) begin
            opcode = tbl[i].op;
            Bcond  = tbl[i].bcond;
            @(negedge clk);
            check(tbl[i].name, act(), tbl[i].exp);
            next_cycle();
        end
        Bcond = 1'b0;

        // ---- MULI: two stall cycles then the write; opcode changes ignored ----
        opcode = {2'b00, OP_MULI};
        @(negedge clk);
        check("muli_c1", act(), ev(0, 1, 0, 1, 0, ALU_MUL));
        next_cycle();
        opcode = {2'b00, OP_SUB};
        @(negedge clk);
        check("muli_c2", act(), ev(0, 1, 0, 1, 0, ALU_MUL));
        check_state("muli_c2_state", ST_MWAIT);
        next_cycle();
        @(negedge clk);
        check("muli_c3", act(), ev(1, 0, 1, 1, 0, ALU_MUL));
        next_cycle();
        @(negedge clk);
        check("after_muli_sub", act(), ev(1, 0, 1, 0, 0, ALU_SUB));
        next_cycle();

        // ---- BAT, Bcond=0, switch low: stall; opcode/Bcond changes ignored ----
        opcode = {2'b00, OP_BAT};
        Bcond  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bat_wait_%0d", i), act(), ev(0, 1, 0, 0, 0, ALU_NOP));
            next_cycle();
            opcode = {2'b00, OP_ADD};
            Bcond  = 1'b1;
        end
        // Switch rises; the cycle it is applied counts as cycle 1.
        Bstus = 1'b1;
        for (int i = 1; i <= SYNC_STAGES; i++) begin
            @(negedge clk);
            check($sformatf("bat_sync_%0d", i), act(), ev(0, 1, 0, 0, 0, ALU_NOP));
            next_cycle();
        end
        @(negedge clk);
        check("bat_release", act(), ev(1, 0, 0, 0, 0, ALU_NOP));
        next_cycle();
        Bcond = 1'b0;
        @(negedge clk);
        check("after_bat_add", act(), ev(1, 0, 1, 0, 0, ALU_ADD));
        check_state("after_bat_state", ST_RUN);
        Bstus = 1'b0;
        next_cycle();

        // ---- Reset in the second MUL stall cycle aborts without a write ----
        opcode = {2'b00, OP_MUL};
        @(negedge clk);
        check("mul_c1", act(), ev(0, 1, 0, 0, 0, ALU_MUL));
        next_cycle();
        @(negedge clk);
        check("mul_c2", act(), ev(0, 1, 0, 0, 0, ALU_MUL));
        #1 reset = 1'b1;
        #1 check("mul_reset_now", act(), 10'b0);
        next_cycle();
        @(negedge clk);
        check("mul_reset_hold", act(), 10'b0);
        next_cycle();
        reset  = 1'b0;
        opcode = {2'b00, OP_NOP};
        @(negedge clk);
        check_state("mul_abort_state", ST_RUN);
        check("mul_abort_nop", act(), ev(1, 0, 0, 0, 0, ALU_NOP));
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
